// File: rtl/ula_mc.sv
// Multi-cycle ALU for the MIPS datapath. Uses the opcode map of the single-cycle ULA.
// Operands are captured on a start/done handshake. Logic, arithmetic and shift ops
// complete in one FIN cycle. MUL (shift-add) and DIV (restoring) each retire one bit
// per cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start      request, accepted only in IDLE
//   OP         4-bit opcode
//   In1, In2   operands (In2[SHW-1:0] is the shift amount)
//   busy       high while a MUL/DIV is iterating
//   done       one-cycle pulse when the outputs below are updated
//   result     primary result (MUL: low product, DIV: quotient)
//   hi         MUL: high product, DIV: remainder, otherwise 0
//   Zero_flag  result == 0
//   div0       last DIV had In2 == 0
//   illegal    last OP was 0000 or 1011
module ula_mc #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       OP,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             Zero_flag,
  output logic             div0,
  output logic             illegal
);

  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [3:0] OpAdd = 4'b0001, OpSub = 4'b0010, OpAnd = 4'b0011, OpOr  = 4'b0100;
  localparam logic [3:0] OpXor = 4'b0101, OpNot = 4'b0110, OpSll = 4'b0111, OpSrl = 4'b1000;
  localparam logic [3:0] OpSra = 4'b1001, OpSlt = 4'b1010, OpMul = 4'b1100, OpDiv = 4'b1101;
  localparam logic [3:0] OpInc = 4'b1110, OpDec = 4'b1111;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFin} state_e;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  // Shared iteration registers: MUL {partial product high, multiplier/low product},
  // DIV {partial remainder, dividend/quotient}.
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d;
  logic             zero_q, zero_d, div0_q, div0_d, illegal_q, illegal_d, done_q, done_d;

  logic [WIDTH:0]   mul_sum, div_trial, div_diff;
  logic             div_ge;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res, alu_hi;
  logic             alu_ill;

  // One shift-add step: add multiplicand when multiplier LSB is set, then shift right.
  assign mul_sum   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? a_q : '0)};
  // One restoring step: bring in the next dividend bit, subtract if it fits.
  assign div_trial = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff  = div_trial - {1'b0, b_q};
  assign div_ge    = (div_trial >= {1'b0, b_q});
  assign shamt     = b_q[SHW-1:0];

  always_comb begin
    alu_res = '0;
    alu_hi  = '0;
    alu_ill = 1'b0;
    case (op_q)
      OpAdd: alu_res = a_q + b_q;
      OpSub: alu_res = a_q - b_q;
      OpAnd: alu_res = a_q & b_q;
      OpOr:  alu_res = a_q | b_q;
      OpXor: alu_res = a_q ^ b_q;
      OpNot: alu_res = ~a_q;
      OpSll: alu_res = a_q << shamt;
      OpSrl: alu_res = a_q >> shamt;
      OpSra: alu_res = $unsigned($signed(a_q) >>> shamt);
      OpSlt: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OpInc: alu_res = a_q + WIDTH'(1);
      OpDec: alu_res = a_q - WIDTH'(1);
      OpMul: begin
        alu_res = acc_lo_q;
        alu_hi  = acc_hi_q;
      end
      OpDiv: begin
        if (b_q == '0) begin
          alu_res = '1;
          alu_hi  = a_q;
        end else begin
          alu_res = acc_lo_q;
          alu_hi  = acc_hi_q;
        end
      end
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    result_d  = result_q;
    hi_d      = hi_q;
    zero_d    = zero_q;
    div0_d    = div0_q;
    illegal_d = illegal_q;
    done_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          op_d     = OP;
          a_d      = In1;
          b_d      = In2;
          cnt_d    = '0;
          acc_hi_d = '0;
          if (OP == OpMul) begin
            acc_lo_d = In2;
            state_d  = StMul;
          end else if (OP == OpDiv && In2 != '0) begin
            acc_lo_d = In1;
            state_d  = StDiv;
          end else begin
            state_d  = StFin;
          end
        end
      end
      StMul: begin
        acc_hi_d = mul_sum[WIDTH:1];
        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH - 1)) state_d = StFin;
      end
      StDiv: begin
        acc_hi_d = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
        acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH - 1)) state_d = StFin;
      end
      StFin: begin
        result_d  = alu_res;
        hi_d      = alu_hi;
        zero_d    = (alu_res == '0);
        div0_d    = (op_q == OpDiv) && (b_q == '0);
        illegal_d = alu_ill;
        done_d    = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      result_q  <= '0;
      hi_q      <= '0;
      zero_q    <= 1'b1;
      div0_q    <= 1'b0;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      result_q  <= result_d;
      hi_q      <= hi_d;
      zero_q    <= zero_d;
      div0_q    <= div0_d;
      illegal_q <= illegal_d;
      done_q    <= done_d;
    end
  end

  assign busy      = (state_q == StMul) || (state_q == StDiv);
  assign done      = done_q;
  assign result    = result_q;
  assign hi        = hi_q;
  assign Zero_flag = zero_q;
  assign div0      = div0_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_ula_mc.sv
// Self-checking bench for ula_mc at WIDTH=32 and WIDTH=8 against an arithmetic model.
module tb_ula_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start32, start8;
  logic [3:0]  op;
  logic [31:0] in1, in2;
  logic        busy32, done32, zf32, d032, ill32;
  logic [31:0] res32, hi32;
  logic        busy8, done8, zf8, d08, ill8;
  logic [7:0]  res8, hi8;

  ula_mc #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .OP(op), .In1(in1), .In2(in2),
    .busy(busy32), .done(done32), .result(res32), .hi(hi32), .Zero_flag(zf32),
    .div0(d032), .illegal(ill32)
  );

  ula_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .OP(op), .In1(in1[7:0]), .In2(in2[7:0]),
    .busy(busy8), .done(done8), .result(res8), .hi(hi8), .Zero_flag(zf8),
    .div0(d08), .illegal(ill8)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] o_r, o_h;
  logic        o_z, o_d0, o_ill, o_busy, o_done;

  // Reference: plain arithmetic on 64-bit values masked to w bits.
  function automatic void model(input int w, input logic [3:0] o, input logic [63:0] a_in,
                                input logic [63:0] b_in, output logic [63:0] r,
                                output logic [63:0] h, output logic d0, output logic ill,
                                output int lat);
    logic [63:0] m, a, b, p;
    logic signed [63:0] sa, sb, t;
    int sh;
    m  = (64'd1 << w) - 64'd1;
    a  = a_in & m;
    b  = b_in & m;
    sh = int'(b % 64'(w));
    sa = a[w-1] ? (a | ~m) : a;
    sb = b[w-1] ? (b | ~m) : b;
    r = 0; h = 0; d0 = 0; ill = 0; lat = 1;
    case (o)
      4'd1:  r = (a + b) & m;
      4'd2:  r = (a - b) & m;
      4'd3:  r = a & b;
      4'd4:  r = a | b;
      4'd5:  r = a ^ b;
      4'd6:  r = ~a & m;
      4'd7:  r = (a << sh) & m;
      4'd8:  r = a >> sh;
      4'd9:  begin t = sa >>> sh; r = t & m; end
      4'd10: r = (sa < sb) ? 64'd1 : 64'd0;
      4'd14: r = (a + 1) & m;
      4'd15: r = (a - 1) & m;
      4'd12: begin p = a * b; r = p & m; h = p >> w; lat = w + 1; end
      4'd13: begin
        if (b == 0) begin r = m; h = a; d0 = 1; end
        else begin r = a / b; h = a % b; lat = w + 1; end
      end
      default: ill = 1;
    endcase
  endfunction

  task automatic sample(input int w);
    if (w == 32) begin
      o_r = {32'd0, res32}; o_h = {32'd0, hi32}; o_z = zf32; o_d0 = d032; o_ill = ill32;
      o_busy = busy32; o_done = done32;
    end else begin
      o_r = {56'd0, res8}; o_h = {56'd0, hi8}; o_z = zf8; o_d0 = d08; o_ill = ill8;
      o_busy = busy8; o_done = done8;
    end
  endtask

  // Issue one request and return the number of edges from accept until done is seen.
  task automatic run_op(input int w, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, output int lat);
    @(negedge clk);
    op = o; in1 = a; in2 = b;
    if (w == 32) start32 = 1'b1; else start8 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0; start8 = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      sample(w);
    end while (!o_done && lat < 100);
  endtask

  task automatic test_reset;
    for (int k = 0; k < 2; k++) begin
      sample(k == 0 ? 32 : 8);
      n_checks++;
      if ({o_busy, o_done, o_r, o_h, o_z, o_d0, o_ill} !== {2'b00, 128'd0, 3'b100}) begin
        n_fail++;
        $display("FAIL reset_w%0d: got busy=%b done=%b r=%h h=%h z=%b d0=%b ill=%b want 0,0,0,0,1,0,0",
                 k == 0 ? 32 : 8, o_busy, o_done, o_r, o_h, o_z, o_d0, o_ill);
      end
    end
  endtask

  typedef struct { logic [3:0] o; logic [31:0] a, b, exp; } vec_t;

  task automatic test_single_ops;
    vec_t v[12];
    logic [63:0] er, eh; logic ed0, eill; int elat, lat;
    v[0]  = '{4'd1,  32'd10, 32'd5, 32'd15};
    v[1]  = '{4'd2,  32'd10, 32'd5, 32'd5};
    v[2]  = '{4'd3,  32'd10, 32'd5, 32'd0};
    v[3]  = '{4'd4,  32'd10, 32'd5, 32'd15};
    v[4]  = '{4'd5,  32'd10, 32'd5, 32'd15};
    v[5]  = '{4'd6,  32'd10, 32'd5, 32'hFFFFFFF5};
    v[6]  = '{4'd7,  32'd10, 32'd2, 32'd40};
    v[7]  = '{4'd8,  32'd10, 32'd2, 32'd2};
    v[8]  = '{4'd9,  32'h80000000, 32'd2, 32'hE0000000};
    v[9]  = '{4'd10, 32'hFFFFFFFF, 32'd5, 32'd1};
    v[10] = '{4'd14, 32'd10, 32'd5, 32'd11};
    v[11] = '{4'd15, 32'd10, 32'd5, 32'd9};
    for (int i = 0; i < 12; i++) begin
      run_op(32, v[i].o, v[i].a, v[i].b, lat);
      model(32, v[i].o, 64'(v[i].a), 64'(v[i].b), er, eh, ed0, eill, elat);
      n_checks++;
      if (lat !== elat || o_r !== 64'(v[i].exp) || o_r !== er || o_h !== eh ||
          o_z !== (er == 0) || o_d0 !== ed0 || o_ill !== eill) begin
        n_fail++;
        $display("FAIL single op=%b: got lat=%0d r=%h h=%h z=%b d0=%b ill=%b want lat=%0d r=%h h=%h z=%b d0=%b ill=%b",
                 v[i].o, lat, o_r, o_h, o_z, o_d0, o_ill, elat, er, eh, er == 0, ed0, eill);
      end
    end
    // done is a single-cycle pulse; outputs hold afterwards.
    @(posedge clk); #1; sample(32);
    n_checks++;
    if (o_done !== 1'b0 || o_r !== 64'd9) begin
      n_fail++;
      $display("FAIL done_pulse: got done=%b r=%h want done=0 r=9", o_done, o_r);
    end
  endtask

  task automatic test_mul_isolation;
    int lat, busy_cycles;
    busy_cycles = 0;
    @(negedge clk);
    op = 4'd12; in1 = 32'hFFFFFFFF; in2 = 32'd2; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    lat = 0;
    sample(32);
    if (o_busy) busy_cycles++;
    do begin
      if (lat == 5) begin op = 4'd1; in1 = 32'd3; in2 = 32'd4; start32 = 1'b1; end
      if (lat == 6) start32 = 1'b0;
      @(posedge clk); #1;
      lat++;
      sample(32);
      if (o_busy) busy_cycles++;
    end while (!o_done && lat < 100);
    n_checks++;
    if (lat !== 33 || busy_cycles !== 32 || o_r !== 64'hFFFFFFFE || o_h !== 64'd1 || o_z !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_isolation: got lat=%0d busy=%0d r=%h h=%h z=%b want 33,32,fffffffe,1,0",
               lat, busy_cycles, o_r, o_h, o_z);
    end
    // The stray start must not have queued anything.
    repeat (3) begin @(posedge clk); #1; end
    sample(32);
    n_checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_r !== 64'hFFFFFFFE) begin
      n_fail++;
      $display("FAIL mul_stray_start: got busy=%b done=%b r=%h want 0,0,fffffffe", o_busy, o_done, o_r);
    end
  endtask

  task automatic test_div;
    int lat;
    run_op(32, 4'd13, 32'd10, 32'd3, lat);
    n_checks++;
    if (lat !== 33 || o_r !== 64'd3 || o_h !== 64'd1 || o_d0 !== 1'b0) begin
      n_fail++;
      $display("FAIL div_10_3: got lat=%0d r=%h h=%h d0=%b want 33,3,1,0", lat, o_r, o_h, o_d0);
    end
    run_op(32, 4'd13, 32'd7, 32'd0, lat);
    n_checks++;
    if (lat !== 1 || o_r !== 64'hFFFFFFFF || o_h !== 64'd7 || o_d0 !== 1'b1) begin
      n_fail++;
      $display("FAIL div_by_zero: got lat=%0d r=%h h=%h d0=%b want 1,ffffffff,7,1", lat, o_r, o_h, o_d0);
    end
  endtask

  task automatic test_illegal_wrap;
    int lat;
    run_op(32, 4'b1011, 32'd10, 32'd5, lat);
    n_checks++;
    if (lat !== 1 || o_ill !== 1'b1 || o_r !== 64'd0 || o_h !== 64'd0 || o_z !== 1'b1 || o_d0 !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal: got lat=%0d ill=%b r=%h h=%h z=%b d0=%b want 1,1,0,0,1,0",
               lat, o_ill, o_r, o_h, o_z, o_d0);
    end
    run_op(32, 4'd1, 32'hFFFFFFFF, 32'd1, lat);
    n_checks++;
    if (lat !== 1 || o_ill !== 1'b0 || o_r !== 64'd0 || o_z !== 1'b1) begin
      n_fail++;
      $display("FAIL add_wrap: got lat=%0d ill=%b r=%h z=%b want 1,0,0,1", lat, o_ill, o_r, o_z);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    op = 4'd1; in1 = 32'd1; in2 = 32'd2; start32 = 1'b1;
    @(posedge clk); #1;           // accept (N)
    @(posedge clk); #1;           // done of first op (N+1); start still high
    sample(32);
    n_checks++;
    if (o_done !== 1'b1 || o_r !== 64'd3) begin
      n_fail++;
      $display("FAIL b2b_first: got done=%b r=%h want 1,3", o_done, o_r);
    end
    op = 4'd2; in1 = 32'd9; in2 = 32'd4;
    @(posedge clk); #1;           // second accept (N+2)
    start32 = 1'b0;
    @(posedge clk); #1;           // second done (N+3)
    sample(32);
    n_checks++;
    if (o_done !== 1'b1 || o_r !== 64'd5) begin
      n_fail++;
      $display("FAIL b2b_second: got done=%b r=%h want 1,5", o_done, o_r);
    end
  endtask

  task automatic test_reset_abort;
    int lat, seen;
    seen = 0;
    @(negedge clk);
    op = 4'd12; in1 = 32'd123; in2 = 32'd456; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    sample(32);
    n_checks++;
    if ({o_busy, o_done, o_r, o_h, o_z, o_d0, o_ill} !== {2'b00, 128'd0, 3'b100}) begin
      n_fail++;
      $display("FAIL reset_abort: got busy=%b done=%b r=%h h=%h z=%b d0=%b ill=%b want 0,0,0,0,1,0,0",
               o_busy, o_done, o_r, o_h, o_z, o_d0, o_ill);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done32) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL reset_no_done: got %0d done pulses want 0", seen);
    end
    run_op(32, 4'd1, 32'd3, 32'd4, lat);
    n_checks++;
    if (lat !== 1 || o_r !== 64'd7) begin
      n_fail++;
      $display("FAIL add_after_reset: got lat=%0d r=%h want 1,7", lat, o_r);
    end
  endtask

  task automatic test_width8;
    int lat;
    run_op(8, 4'd12, 32'hFF, 32'hFF, lat);
    n_checks++;
    if (lat !== 9 || o_h !== 64'hFE || o_r !== 64'h01) begin
      n_fail++;
      $display("FAIL mul8: got lat=%0d h=%h r=%h want 9,fe,01", lat, o_h, o_r);
    end
    run_op(8, 4'd13, 32'd200, 32'd7, lat);
    n_checks++;
    if (lat !== 9 || o_r !== 64'd28 || o_h !== 64'd4 || o_d0 !== 1'b0) begin
      n_fail++;
      $display("FAIL div8: got lat=%0d r=%h h=%h d0=%b want 9,1c,4,0", lat, o_r, o_h, o_d0);
    end
    run_op(8, 4'd13, 32'd5, 32'd0, lat);
    n_checks++;
    if (lat !== 1 || o_r !== 64'hFF || o_h !== 64'd5 || o_d0 !== 1'b1) begin
      n_fail++;
      $display("FAIL div8_by_zero: got lat=%0d r=%h h=%h d0=%b want 1,ff,5,1", lat, o_r, o_h, o_d0);
    end
  endtask

  task automatic test_random;
    logic [63:0] er, eh; logic ed0, eill; int elat, lat, w;
    logic [3:0] o; logic [31:0] a, b;
    for (int i = 0; i < 80; i++) begin
      w = (i % 2 == 0) ? 32 : 8;
      o = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 3);
      run_op(w, o, a, b, lat);
      model(w, o, 64'(a), 64'(b), er, eh, ed0, eill, elat);
      n_checks++;
      if (lat !== elat || o_r !== er || o_h !== eh || o_z !== (er == 0) || o_d0 !== ed0 ||
          o_ill !== eill) begin
        n_fail++;
        $display("FAIL random w=%0d op=%b a=%h b=%h: got lat=%0d r=%h h=%h z=%b d0=%b ill=%b want lat=%0d r=%h h=%h z=%b d0=%b ill=%b",
                 w, o, a, b, lat, o_r, o_h, o_z, o_d0, o_ill, elat, er, eh, er == 0, ed0, eill);
      end
      @(posedge clk); #1;
      sample(w);
      n_checks++;
      if (o_done !== 1'b0 || o_r !== er || o_h !== eh) begin
        n_fail++;
        $display("FAIL random_hold w=%0d: got done=%b r=%h h=%h want 0,%h,%h", w, o_done, o_r, o_h, er, eh);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start32 = 1'b0; start8 = 1'b0; op = '0; in1 = '0; in2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_single_ops();
    test_mul_isolation();
    test_div();
    test_illegal_wrap();
    test_back_to_back();
    test_reset_abort();
    test_width8();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
